// File: rtl/aes_128_inv_control_4cyc_3val.sv
// Control FSM for the AES-128 inverse cipher: one key expansion into RAM, then 3-block bursts
// replaying round keys NR..0. Optional collision irq enabled by macro AES_INV_COLLISION_IRQ_EN.
module aes_128_inv_control_4cyc_3val #(
    parameter int NR    = 10,
    parameter int SLOTS = 3
) (
    input  logic       clk,
    input  logic       kill_n,
    input  logic       key_load,
    input  logic       in_en,
    output logic       start,
    output logic       key_exp_step,
    output logic       key_wr_en,
    output logic [3:0] key_wr_addr,
    output logic [3:0] key_rd_addr,
    output logic       key_valid,
    output logic       en_invmixcol,
    output logic       busy,
    output logic       out_en,
    output logic       in_en_collision_irq_pulse
);

    typedef enum logic [1:0] {
        NOKEY  = 2'd0,
        KEYEXP = 2'd1,
        READY  = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [3:0] LAST_KEY = 4'(NR);
    localparam logic [5:0] LAST_CNT = 6'(4 * NR);
    localparam logic [5:0] IMC_OFF  = 6'(4 * NR - 5);
    localparam logic [5:0] OUT0_CNT = 6'(4 * NR - 2);
    localparam logic [1:0] SLOT_MAX = 2'(SLOTS);

    state_t             state_q, state_d;
    logic [3:0]         step_cnt_q, step_cnt_d;
    logic [5:0]         round_count_q, round_count_d;
    logic [1:0]         acc_cnt_q, acc_cnt_d;
    logic               acc_open_q, acc_open_d;
    logic [SLOTS-1:0]   slot_valid_q, slot_valid_d;
    logic [3:0]         key_rd_addr_q, key_rd_addr_d;
    logic               key_valid_q, key_valid_d;
    logic               en_invmixcol_q, en_invmixcol_d;
    logic               out_en_q, out_en_d;

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            state_q        <= NOKEY;
            step_cnt_q     <= '0;
            round_count_q  <= '0;
            acc_cnt_q      <= '0;
            acc_open_q     <= 1'b0;
            slot_valid_q   <= '0;
            key_rd_addr_q  <= LAST_KEY;
            key_valid_q    <= 1'b0;
            en_invmixcol_q <= 1'b0;
            out_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_cnt_q     <= step_cnt_d;
            round_count_q  <= round_count_d;
            acc_cnt_q      <= acc_cnt_d;
            acc_open_q     <= acc_open_d;
            slot_valid_q   <= slot_valid_d;
            key_rd_addr_q  <= key_rd_addr_d;
            key_valid_q    <= key_valid_d;
            en_invmixcol_q <= en_invmixcol_d;
            out_en_q       <= out_en_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        step_cnt_d     = step_cnt_q;
        round_count_d  = round_count_q;
        acc_cnt_d      = acc_cnt_q;
        acc_open_d     = acc_open_q;
        slot_valid_d   = slot_valid_q;
        key_rd_addr_d  = key_rd_addr_q;
        key_valid_d    = key_valid_q;
        en_invmixcol_d = en_invmixcol_q;
        out_en_d       = 1'b0;
        start          = 1'b0;
        key_exp_step   = 1'b0;
        key_wr_en      = 1'b0;
        key_wr_addr    = 4'd0;
        busy           = 1'b0;

        case (state_q)
            NOKEY: begin
                if (key_load) begin
                    state_d    = KEYEXP;
                    step_cnt_d = '0;
                end
            end
            KEYEXP: begin
                busy         = 1'b1;
                key_wr_en    = 1'b1;
                key_wr_addr  = step_cnt_q;
                key_exp_step = (step_cnt_q != 4'd0);
                if (step_cnt_q == LAST_KEY) begin
                    state_d     = READY;
                    step_cnt_d  = '0;
                    key_valid_d = 1'b1;
                end else begin
                    step_cnt_d = step_cnt_q + 4'd1;
                end
            end
            READY: begin
                key_rd_addr_d = LAST_KEY;
                // An arriving block wins over a simultaneous re-key request.
                if (in_en) begin
                    start          = 1'b1;
                    state_d        = RUN;
                    round_count_d  = '0;
                    acc_cnt_d      = 2'd1;
                    acc_open_d     = 1'b1;
                    slot_valid_d   = '0;
                    slot_valid_d[0] = 1'b1;
                    en_invmixcol_d = 1'b1;
                end else if (key_load) begin
                    state_d     = KEYEXP;
                    step_cnt_d  = '0;
                    key_valid_d = 1'b0;
                end
            end
            RUN: begin
                busy          = 1'b1;
                round_count_d = round_count_q + 6'd1;
                // A gap in the incoming blocks closes the accept window for this burst.
                if (in_en && acc_open_q && (acc_cnt_q < SLOT_MAX)) begin
                    start                   = 1'b1;
                    slot_valid_d[acc_cnt_q] = 1'b1;
                    acc_cnt_d               = acc_cnt_q + 2'd1;
                end else if (!in_en) begin
                    acc_open_d = 1'b0;
                end
                if (round_count_q[1:0] == 2'd3) begin
                    key_rd_addr_d = (LAST_KEY - 4'd1) - round_count_q[5:2];
                end
                if (round_count_q == IMC_OFF) begin
                    en_invmixcol_d = 1'b0;
                end
                if (round_count_q == OUT0_CNT) begin
                    out_en_d = slot_valid_q[0];
                end else if (round_count_q == OUT0_CNT + 6'd1) begin
                    out_en_d = slot_valid_q[1];
                end else if (round_count_q == OUT0_CNT + 6'd2) begin
                    out_en_d = slot_valid_q[2];
                end
                if (round_count_q == LAST_CNT) begin
                    state_d       = READY;
                    round_count_d = '0;
                    acc_cnt_d     = '0;
                    acc_open_d    = 1'b0;
                    slot_valid_d  = '0;
                    key_rd_addr_d = LAST_KEY;
                end
            end
            default: state_d = NOKEY;
        endcase
    end

    assign key_rd_addr  = key_rd_addr_q;
    assign key_valid    = key_valid_q;
    assign en_invmixcol = en_invmixcol_q;
    assign out_en       = out_en_q;

`ifdef AES_INV_COLLISION_IRQ_EN
    logic coll_q, coll_d;
    logic irq_q, irq_d;

    always_comb begin
        coll_d = coll_q;
        if (in_en && !start) begin
            coll_d = 1'b1;
        end else if (start) begin
            coll_d = 1'b0;
        end
        irq_d = coll_q ? ~irq_q : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            coll_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            coll_q <= coll_d;
            irq_q  <= irq_d;
        end
    end

    assign in_en_collision_irq_pulse = irq_q;
`else
    assign in_en_collision_irq_pulse = 1'b0;
`endif

endmodule
